// File: rtl/floating_point_divider.sv
// Multi-cycle IEEE-754-style divider: restoring radix-2 mantissa divide, round to nearest even.
// Define FP_DIVIDER_EARLY_OUT_EN to return NaN/Inf/zero-operand results one cycle after accept.
module floating_point_divider #(
  parameter int EXPONENT_WIDTH  = 8,
  parameter int MANTISSA_WIDTH  = 23,
  parameter int FLOAT_BIT_WIDTH = EXPONENT_WIDTH + MANTISSA_WIDTH + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FLOAT_BIT_WIDTH-1:0] a,
  input  logic [FLOAT_BIT_WIDTH-1:0] b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FLOAT_BIT_WIDTH-1:0] out,
  output logic                       underflow_flag,
  output logic                       overflow_flag,
  output logic                       invalid_operation_flag,
  output logic                       divide_by_zero_flag
);
  localparam int EW        = EXPONENT_WIDTH;
  localparam int MW        = MANTISSA_WIDTH;
  localparam int FW        = FLOAT_BIT_WIDTH;
  localparam int CW        = $clog2(MW + 3);
  localparam int BIAS      = (1 << (EW - 1)) - 1;
  localparam int EXP_MAX_I = (1 << EW) - 1;
  localparam int LAST_I    = MW + 1;
  localparam logic signed [EW+1:0] BIAS_S  = BIAS[EW+1:0];
  localparam logic signed [EW+1:0] ONE_S   = {{(EW+1){1'b0}}, 1'b1};
  localparam logic signed [EW+1:0] ZERO_S  = '0;
  localparam logic [EW:0]          EXP_MAX = EXP_MAX_I[EW:0];
  localparam logic [CW-1:0]        LAST    = LAST_I[CW-1:0];
  localparam logic [FW-1:0]        QNAN    = {1'b1, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

  // Returns {underflow, overflow, packed result}.
  function automatic logic [FW+1:0] round_pack(input logic sign, input logic signed [EW+1:0] exp,
                                               input logic [MW+1:0] q, input logic sticky);
    logic                 up;
    logic [MW+1:0]        m;
    logic signed [EW+1:0] e;
    logic [MW-1:0]        frac;
    up   = q[0] & (sticky | q[1]);
    m    = {1'b0, q[MW+1:1]} + {{(MW+1){1'b0}}, up};
    e    = exp + (m[MW+1] ? ONE_S : ZERO_S);
    frac = m[MW+1] ? m[MW:1] : m[MW-1:0];
    if (!e[EW+1] && e[EW:0] >= EXP_MAX)
      round_pack = {2'b01, sign, {EW{1'b1}}, {MW{1'b0}}};
    else if (e[EW+1] || e == ZERO_S)
      round_pack = {2'b10, sign, {(FW-1){1'b0}}};
    else
      round_pack = {2'b00, sign, e[EW-1:0], frac};
  endfunction

  logic                 w_sa, w_sb, w_sign;
  logic [EW-1:0]        w_ea, w_eb;
  logic [MW-1:0]        w_fa, w_fb;
  logic                 w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic                 w_spec, w_early, w_accept, w_a_lt, w_qbit;
  logic [FW-1:0]        w_spec_out;
  logic [3:0]           w_spec_flg;
  logic [MW:0]          w_ma, w_mb;
  logic [MW+1:0]        w_rem0, w_diff, w_rem_nxt;
  logic signed [EW+1:0] w_exp0;
  logic [FW+1:0]        w_rnd;
  state_t               r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [MW+1:0]        r_rem, r_q;
  logic [MW:0]          r_div;
  logic signed [EW+1:0] r_exp;
  logic                 r_sign, r_spec;
  logic [FW-1:0]        r_spec_out, r_out;
  logic [3:0]           r_spec_flg, r_flg;

  assign {w_sa, w_ea, w_fa} = a;
  assign {w_sb, w_eb, w_fb} = b;
  assign w_sign   = w_sa ^ w_sb;
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (&w_ea) && (w_fa == '0);
  assign w_b_inf  = (&w_eb) && (w_fb == '0);
  assign w_a_nan  = (&w_ea) && (w_fa != '0);
  assign w_b_nan  = (&w_eb) && (w_fb != '0);

  // Flag nibble order is {underflow, overflow, invalid, divide_by_zero}.
  always_comb begin
    w_spec     = 1'b1;
    w_spec_out = '0;
    w_spec_flg = '0;
    if (w_a_nan) begin
      w_spec_out = w_fa[MW-1] ? a : QNAN;
      w_spec_flg = 4'b0010;
    end else if (w_b_nan) begin
      w_spec_out = w_fb[MW-1] ? b : QNAN;
      w_spec_flg = 4'b0010;
    end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_spec_out = QNAN;
      w_spec_flg = 4'b0010;
    end else if (w_a_inf) begin
      w_spec_out = {w_sign, {EW{1'b1}}, {MW{1'b0}}};
      w_spec_flg = 4'b0100;
    end else if (w_b_zero) begin
      w_spec_out = {w_sign, {EW{1'b1}}, {MW{1'b0}}};
      w_spec_flg = 4'b0001;
    end else if (w_a_zero || w_b_inf) begin
      w_spec_out = {w_sign, {(FW-1){1'b0}}};
    end else begin
      w_spec = 1'b0;
    end
  end

`ifdef FP_DIVIDER_EARLY_OUT_EN
  assign w_early = w_spec;
`else
  assign w_early = 1'b0;
`endif

  // Pre-shifting a smaller dividend makes the first quotient bit always 1.
  assign w_ma      = {1'b1, w_fa};
  assign w_mb      = {1'b1, w_fb};
  assign w_a_lt    = (w_ma < w_mb);
  assign w_rem0    = w_a_lt ? {w_ma, 1'b0} : {1'b0, w_ma};
  assign w_exp0    = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + BIAS_S
                     - (w_a_lt ? ONE_S : ZERO_S);
  assign w_qbit    = (r_rem >= {1'b0, r_div});
  assign w_diff    = r_rem - (w_qbit ? {1'b0, r_div} : '0);
  assign w_rem_nxt = w_diff << 1;
  assign w_accept  = in_valid && in_ready;
  assign w_rnd     = round_pack(r_sign, r_exp, r_q, |r_rem);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (r_state == DIVIDE) ? r_cnt + {{(CW-1){1'b0}}, 1'b1} : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = w_early ? DONE : DIVIDE;
      end
      DIVIDE:  if (r_cnt == LAST) w_state_nxt = ROUND;
      ROUND:   w_state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rem      <= w_rem0;
      r_div      <= w_mb;
      r_exp      <= w_exp0;
      r_sign     <= w_sign;
      r_spec     <= w_spec;
      r_spec_out <= w_spec_out;
      r_spec_flg <= w_spec_flg;
    end else if (r_state == DIVIDE) begin
      r_q   <= {r_q[MW:0], w_qbit};
      r_rem <= w_rem_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
      r_flg <= '0;
    end else if (w_accept && w_early) begin
      r_out <= w_spec_out;
      r_flg <= w_spec_flg;
    end else if (r_state == ROUND) begin
      r_out <= r_spec ? r_spec_out : w_rnd[FW-1:0];
      r_flg <= r_spec ? r_spec_flg : {w_rnd[FW+1:FW], 2'b00};
    end
  end

  assign out = r_out;
  assign {underflow_flag, overflow_flag, invalid_operation_flag, divide_by_zero_flag} = r_flg;
endmodule

// File: tb/tb_floating_point_divider.sv
// Bench for floating_point_divider (fp32): directed table, handshake/reset sequences, random vs real-arithmetic model.
module tb_floating_point_divider;
`ifdef FP_DIVIDER_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] out;
  logic        in_ready, out_valid, uf, of, inv, dz;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] o;
    logic [3:0]  fl;
    bit          sp;
  } vec_t;
  vec_t tbl [16];

  floating_point_divider dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .underflow_flag(uf), .overflow_flag(of),
    .invalid_operation_flag(inv), .divide_by_zero_flag(dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp_v);
    end
  endtask

  function automatic int exp_lat(input bit sp);
    return (sp && EARLY) ? 1 : 27;
  endfunction

  function automatic logic [63:0] to_dbl(input logic [31:0] x);
    logic [10:0] e11;
    e11 = {3'b000, x[30:23]} + 11'd896;
    return {x[31], e11, x[22:0], 29'd0};
  endfunction

  // Flags {underflow, overflow, invalid, divide_by_zero}; sp marks zero/Inf/NaN operand cases.
  function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] o, output logic [3:0] fl, output bit sp);
    bit          xz, yz, xi, yi, xn, yn, s;
    real         q;
    logic [63:0] qb;
    int          e;
    longint      m;
    xz = (x[30:23] == 8'h00);
    yz = (y[30:23] == 8'h00);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    s  = x[31] ^ y[31];
    sp = 1'b1;
    fl = 4'b0000;
    o  = 32'd0;
    if (xn) begin
      o = x[22] ? x : 32'hFFC00000; fl = 4'b0010;
    end else if (yn) begin
      o = y[22] ? y : 32'hFFC00000; fl = 4'b0010;
    end else if ((xz && yz) || (xi && yi)) begin
      o = 32'hFFC00000; fl = 4'b0010;
    end else if (xi) begin
      o = {s, 8'hFF, 23'd0}; fl = 4'b0100;
    end else if (yz) begin
      o = {s, 8'hFF, 23'd0}; fl = 4'b0001;
    end else if (xz || yi) begin
      o = {s, 31'd0};
    end else begin
      sp = 1'b0;
      q  = $bitstoreal(to_dbl(x)) / $bitstoreal(to_dbl(y));
      qb = $realtobits(q);
      e  = int'(qb[62:52]) - 1023 + 127;
      m  = longint'({1'b1, qb[51:29]});
      if (qb[28:0] > 29'h1000_0000 || (qb[28:0] == 29'h1000_0000 && qb[29])) m = m + 1;
      if (m == (longint'(1) << 24)) begin
        m = m >> 1;
        e = e + 1;
      end
      if (e >= 255) begin
        o = {s, 8'hFF, 23'd0}; fl = 4'b0100;
      end else if (e <= 0) begin
        o = {s, 31'd0}; fl = 4'b1000;
      end else begin
        o = {s, e[7:0], m[22:0]};
      end
    end
  endfunction

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [31:0] xa, input logic [31:0] xb,
                        output logic [31:0] o, output logic [3:0] fl, output int lat);
    a = xa; b = xb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    o  = out;
    fl = {uf, of, inv, dz};
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] o, eo, ra, rb;
    logic [3:0]  fl, efl;
    bit          sp;
    int          lat;

    tbl[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 1'b0};
    tbl[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 1'b0};
    tbl[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0001, 1'b1};
    tbl[3]  = '{32'h00000000, 32'h00000000, 32'hFFC00000, 4'b0010, 1'b1};
    tbl[4]  = '{32'hFFA00000, 32'h3F800000, 32'hFFC00000, 4'b0010, 1'b1};
    tbl[5]  = '{32'hFFC00001, 32'h3F800000, 32'hFFC00001, 4'b0010, 1'b1};
    tbl[6]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0100, 1'b0};
    tbl[7]  = '{32'h00800000, 32'h40000000, 32'h00000000, 4'b1000, 1'b0};
    tbl[8]  = '{32'h7F800000, 32'h40000000, 32'h7F800000, 4'b0100, 1'b1};
    tbl[9]  = '{32'h40000000, 32'h7F800000, 32'h00000000, 4'b0000, 1'b1};
    tbl[10] = '{32'h7F800000, 32'hFF800000, 32'hFFC00000, 4'b0010, 1'b1};
    tbl[11] = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 1'b0};
    tbl[12] = '{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 1'b1};
    tbl[13] = '{32'h3F800000, 32'h80000000, 32'hFF800000, 4'b0001, 1'b1};
    tbl[14] = '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 4'b0000, 1'b0};
    tbl[15] = '{32'h3F800000, 32'h7FC00000, 32'h7FC00000, 4'b0010, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset out", out, 0);
    chk("reset flags", {uf, of, inv, dz}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset in_ready", in_ready, 1);
    chk("post-reset out_valid", out_valid, 0);

    for (int i = 0; i < 16; i++) begin
      run_op(tbl[i].a, tbl[i].b, o, fl, lat);
      chk($sformatf("vec%0d out", i), o, tbl[i].o);
      chk($sformatf("vec%0d flags", i), fl, tbl[i].fl);
      chk($sformatf("vec%0d latency", i), lat, exp_lat(tbl[i].sp));
    end

    // Backpressure, then a back-to-back issue queued during the DONE cycle.
    a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    chk("bp latency", lat, 27);
    for (int k = 0; k < 10; k++) begin
      chk("bp out stable", out, 32'h40400000);
      chk("bp flags stable", {uf, of, inv, dz}, 0);
      chk("bp in_ready low", in_ready, 0);
      chk("bp out_valid held", out_valid, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1; a = 32'h3F800000; b = 32'h40400000; in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b in_ready at D+1", in_ready, 1);
    chk("b2b out_valid dropped", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b accepted", in_ready, 0);
    wait_out(lat);
    chk("b2b latency", lat, 27);
    chk("b2b out", out, 32'h3EAAAAAB);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of DIVIDE.
    a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst in_ready", in_ready, 1);
    chk("midrst out", out, 0);
    chk("midrst flags", {uf, of, inv, dz}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("midrst discarded", out_valid, 0);
    chk("midrst idle", in_ready, 1);
    run_op(32'h40C00000, 32'h40000000, o, fl, lat);
    chk("after rst out", o, 32'h40400000);
    chk("after rst latency", lat, 27);

    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        ra[30:23] = 8'($urandom_range(100, 154));
        rb[30:23] = 8'($urandom_range(100, 154));
      end
      ref_div(ra, rb, eo, efl, sp);
      run_op(ra, rb, o, fl, lat);
      chk($sformatf("rnd %h/%h out", ra, rb), o, eo);
      chk($sformatf("rnd %h/%h flags", ra, rb), fl, efl);
      chk($sformatf("rnd %h/%h latency", ra, rb), lat, exp_lat(sp));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
